// File: rtl/q_bus_pkg.sv
// q_bus_pkg: shared FSM states, bus widths, timeout pattern and ring helper
// for the q_bus arbiter.
package q_bus_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, STROBE, RELEASE} state_t;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam logic [DW-1:0] ERR_PAT = 16'hDEAD;

    function automatic int rr_slot(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/q_rr_picker.sv
// q_rr_picker: combinational round-robin selector, first set request at or
// above ptr, wrapping modulo N.
module q_rr_picker
    import q_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    int j;

    // Scan from the farthest slot down so the nearest set request wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = rr_slot(int'(ptr), k, N);
            if (req[j]) begin
                gnt = N'(1) << j;
                idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/q_bus_arbiter.sv
// q_bus_arbiter: round-robin arbiter sequencing one q_bus as/ds/da transfer per grant.
// Optional da timeout with error pulse when Q_BUS_ARB_TIMEOUT_EN is defined.
module q_bus_arbiter
    import q_bus_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_rw,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [DW-1:0]         rdata,
    output logic                  err,
    output logic                  bus_as,
    output logic                  bus_rw,
    output logic                  bus_ds,
    output logic [AW-1:0]         bus_addr,
    output logic [DW-1:0]         bus_wdata,
    output logic                  bus_wdata_oe,
    input  logic                  bus_da,
    input  logic [DW-1:0]         bus_data
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("q_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          to_hit;

    q_rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign sel_rw    = req_rw[pick_idx];
    assign sel_addr  = req_addr[AW*int'(pick_idx) +: AW];
    assign sel_wdata = req_wdata[DW*int'(pick_idx) +: DW];

`ifdef Q_BUS_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CW-1:0] cnt;
    logic          waiting;

    // One counter serves both the da-high wait in STROBE and the da-low wait in RELEASE.
    assign waiting = (state == STROBE && !bus_da) || (state == RELEASE && bus_da);
    assign to_hit  = waiting && cnt == CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (waiting && !to_hit) ? cnt + 1'b1 : '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cur          <= '0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            err          <= 1'b0;
            bus_as       <= 1'b0;
            bus_rw       <= 1'b1;
            bus_ds       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wdata_oe <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    gnt          <= pick_gnt;
                    cur          <= pick_idx;
                    bus_as       <= 1'b1;
                    bus_rw       <= sel_rw;
                    bus_addr     <= sel_addr;
                    bus_wdata    <= sel_wdata;
                    bus_wdata_oe <= !sel_rw;
                    state        <= ADDR;
                end
                ADDR: begin
                    bus_ds <= 1'b1;
                    state  <= STROBE;
                end
                // Without da here the only way out is the timeout.
                STROBE: if (bus_da || to_hit) begin
                    bus_as       <= 1'b0;
                    bus_ds       <= 1'b0;
                    bus_wdata_oe <= 1'b0;
                    done         <= gnt;
                    err          <= !bus_da;
                    rdata        <= !bus_da ? ERR_PAT : bus_rw ? bus_data : rdata;
                    ptr          <= PW'(rr_slot(int'(cur), 1, NUM_REQ));
                    state        <= RELEASE;
                end
                RELEASE: if (!bus_da || to_hit) begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_bus_arbiter.sv
// tb_q_bus_arbiter: vector table, hand sequences and randomized traffic against a
// memory-backed manager and a round-robin/memory reference model.
module tb_q_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_rw = '0;
    logic [N*8-1:0]  req_addr = '0;
    logic [N*16-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, done;
    logic [15:0]     rdata, bus_wdata;
    logic [15:0]     bus_data = '0;
    logic            err, bus_as, bus_rw, bus_ds, bus_wdata_oe;
    logic            bus_da = 1'b0;
    logic [7:0]      bus_addr;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int wcnt  = 0;
    bit no_da = 1'b0;
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];

    q_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .bus_as(bus_as), .bus_rw(bus_rw), .bus_ds(bus_ds), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wdata_oe(bus_wdata_oe), .bus_da(bus_da),
        .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bus manager: memory slave, raises da lat cycles after ds, drops it once ds falls.
    always @(negedge clk) begin
        if (rst) begin
            bus_da = 1'b0;
            wcnt   = 0;
        end else if (bus_ds && !bus_da && !no_da) begin
            if (wcnt >= lat) begin
                bus_da   = 1'b1;
                bus_data = mem[bus_addr];
                if (!bus_rw) mem[bus_addr] = bus_wdata;
            end else wcnt++;
        end else if (!bus_ds) begin
            bus_da = 1'b0;
            wcnt   = 0;
        end
    end

    // Reference model: round-robin order over the sampled request vector plus a shadow memory.
    logic [N-1:0] last_req = '0;
    logic [N-1:0] prev_gnt = '0;
    int mptr = 0;
    int cur  = 0;
    int e;
    bit got_done = 1'b0;
    logic        c_rw;
    logic [7:0]  c_addr;
    logic [15:0] c_wdata;

    always @(posedge clk) last_req = req;

    always @(negedge clk) begin
        if (rst) begin
            mptr     = 0;
            prev_gnt = '0;
        end else begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            chk("ds_needs_as", 32'(bus_ds & ~bus_as), 0);
            if (gnt != 0 && prev_gnt == 0) begin
                e = -1;
                for (int k = 0; k < N; k++)
                    if (e < 0 && last_req[(mptr + k) % N]) e = (mptr + k) % N;
                chk("grant", 32'(gnt), e < 0 ? 0 : 32'(1) << e);
                cur      = e < 0 ? 0 : e;
                got_done = 1'b0;
                c_rw     = req_rw[cur];
                c_addr   = req_addr[cur*8 +: 8];
                c_wdata  = req_wdata[cur*16 +: 16];
            end
            if (bus_as) begin
                chk("bus_addr", 32'(bus_addr), 32'(c_addr));
                chk("bus_rw", 32'(bus_rw), 32'(c_rw));
                chk("bus_oe", 32'(bus_wdata_oe), 32'(!c_rw));
                if (!c_rw) chk("bus_wdata", 32'(bus_wdata), 32'(c_wdata));
            end else chk("oe_idle", 32'(bus_wdata_oe), 0);
            if (done != 0) begin
                chk("done_once", 32'(got_done), 0);
                chk("done_who", 32'(done), 32'(1) << cur);
                chk("err", 32'(err), 32'(no_da));
                if (no_da) chk("rdata_to", 32'(rdata), 32'h0000DEAD);
                else if (c_rw) chk("rdata", 32'(rdata), 32'(ref_mem[c_addr]));
                else ref_mem[c_addr] = c_wdata;
                got_done = 1'b1;
                mptr     = (cur + 1) % N;
            end
            prev_gnt = gnt;
        end
    end

    typedef struct {
        int          idx;
        bit          rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[7];
    int   order[$];
    int   n;

    task automatic do_reset;
        rst   = 1'b1;
        req   = '0;
        no_da = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 32'({gnt, done, err, bus_as, bus_ds, bus_rw, bus_wdata_oe}), 32'h2);
        chk("rst_data", {rdata, bus_wdata}, 0);
        chk("rst_addr", 32'(bus_addr), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic xfer(input vec_t v);
        int m;
        req_rw[v.idx]             = v.rw;
        req_addr[v.idx*8 +: 8]    = v.addr;
        req_wdata[v.idx*16 +: 16] = v.wdata;
        lat                       = v.lat;
        req[v.idx]                = 1'b1;
        m = 0;
        do begin
            @(negedge clk);
            m++;
            if (m == 1) chk("addr_phase", 32'({bus_as, bus_ds, bus_wdata_oe, bus_addr}),
                            32'({1'b1, 1'b0, !v.rw, v.addr}));
            if (m == 2) chk("ds_phase", 32'({bus_as, bus_ds}), 3);
        end while (done == 0 && m < 200);
        chk("latency", m, 3 + v.lat);
        chk("x_done", 32'(done), 32'(1) << v.idx);
        chk("x_err", 32'(err), 0);
        if (v.rw) chk("x_rdata", 32'(rdata), 32'(v.exp));
        req[v.idx] = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a]     = {8'(a), ~8'(a)};
            ref_mem[a] = {8'(a), ~8'(a)};
        end
        mem[8'h3C]     = 16'hBEEF;
        ref_mem[8'h3C] = 16'hBEEF;
        tbl[0] = '{0, 1'b1, 8'h3C, 16'h0000, 2, 16'hBEEF};
        tbl[1] = '{2, 1'b0, 8'hFF, 16'h1234, 0, 16'h0000};
        tbl[2] = '{2, 1'b1, 8'hFF, 16'h0000, 1, 16'h1234};
        tbl[3] = '{3, 1'b0, 8'h00, 16'hA5A5, 3, 16'h0000};
        tbl[4] = '{3, 1'b1, 8'h00, 16'h0000, 0, 16'hA5A5};
        tbl[5] = '{1, 1'b1, 8'h80, 16'h0000, 0, 16'h807F};
        tbl[6] = '{0, 1'b1, 8'hFF, 16'h0000, 4, 16'h1234};

        do_reset;
        for (int i = 0; i < 7; i++) xfer(tbl[i]);

        // Contention: all requesters always pending, each re-raises the cycle after done.
        do_reset;
        lat = 0;
        for (int i = 0; i < N; i++) begin
            req_rw[i]          = 1'b1;
            req_addr[i*8 +: 8] = 8'(i * 16);
        end
        req = '1;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            @(negedge clk);
            if (done != 0) begin
                order.push_back($clog2(done));
                req = ~done;
            end else req = '1;
        end
        chk("cont_count", order.size(), 5);
        for (int k = 0; k < 5 && k < order.size(); k++) chk("cont_order", order[k], k % N);
        req = '0;
        for (n = 0; n < 50 && gnt != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);

        // Back-to-back: requester 1 re-raises right after done while 3 waits.
        do_reset;
        lat = 1;
        req_rw[1] = 1'b0; req_addr[15:8] = 8'h11; req_wdata[31:16] = 16'h5555;
        req_rw[3] = 1'b1; req_addr[31:24] = 8'h11;
        req = 4'b0010;
        for (n = 0; n < 50 && gnt == 0; n++) @(negedge clk);
        req = 4'b1010;
        for (n = 0; n < 50 && done == 0; n++) @(negedge clk);
        chk("b2b_done", 32'(done), 32'h2);
        req = 4'b1000;
        @(negedge clk);
        req = 4'b1010;
        for (n = 0; n < 50 && gnt != 0; n++) @(negedge clk);
        for (n = 0; n < 50 && gnt == 0; n++) @(negedge clk);
        chk("b2b_next", 32'(gnt), 32'h8);
        for (n = 0; n < 50 && done == 0; n++) @(negedge clk);
        req = '0;
        for (n = 0; n < 50 && gnt != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);

        // Reset while ds is high: everything drops at once, no done afterwards.
        do_reset;
        lat = 30;
        req_rw[0] = 1'b1; req_addr[7:0] = 8'h3C;
        req = 4'b0001;
        for (n = 0; n < 50 && !bus_ds; n++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_strobe", 32'({bus_as, bus_ds, bus_wdata_oe, gnt, done}), 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_done", 32'({gnt, done}), 0);
        end
        xfer(tbl[0]);

        // Randomized traffic checked by the reference model.
        do_reset;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            lat = $urandom_range(0, 3);
            for (int i = 0; i < N; i++)
                if (done[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req_rw[i]             = 1'($urandom_range(0, 1));
                    req_addr[i*8 +: 8]    = 8'($urandom_range(0, 15));
                    req_wdata[i*16 +: 16] = 16'($urandom);
                    req[i]                = 1'b1;
                end
        end
        for (int c = 0; c < 400 && (req != 0 || gnt != 0); c++) begin
            @(negedge clk);
            req = req & ~done;
        end
        chk("drain", 32'({req, gnt}), 0);

`ifdef Q_BUS_ARB_TIMEOUT_EN
        do_reset;
        no_da = 1'b1;
        lat = 0;
        req_rw[1:0] = 2'b11;
        req = 4'b0011;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 0 && n < 200);
        chk("to_latency", n, TO + 2);
        chk("to_done", 32'({done, err}), 32'h3);
        chk("to_rdata", 32'(rdata), 32'h0000DEAD);
        req = 4'b0010;
        for (n = 0; n < 50 && gnt != 0; n++) @(negedge clk);
        for (n = 0; n < 50 && gnt == 0; n++) @(negedge clk);
        chk("to_next", 32'(gnt), 32'h2);
        no_da = 1'b0;
        for (n = 0; n < 50 && done == 0; n++) @(negedge clk);
        chk("to_recover", 32'(done), 32'h2);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/q_bus_arbiter.md
Name: q_bus_arbiter

Overview:
- Shares one q_bus (8-bit addr, 16-bit data, as/rw/ds strobes, da acknowledge) between NUM_REQ requester ports.
- Sits between local masters and the bus manager.
- Grants the bus round-robin and sequences the strobe/acknowledge handshake for one transfer per grant.
- Returns the read data and a per-requester completion pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 64, cycles waited for da before abort (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester transfer request, held until done
req_rw  input  NUM_REQ  1=read, 0=write, per requester
req_addr  input  NUM_REQ*8  packed addresses, requester i at [8i+7:8i]
req_wdata  input  NUM_REQ*16  packed write data
gnt  output  NUM_REQ  one-hot grant, valid for the whole transfer
done  output  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  output  16  read data, valid with done
err  output  1  one-cycle pulse with done when the transfer timed out
bus_as  output  1  address strobe
bus_rw  output  1  read/write qualifier
bus_ds  output  1  data strobe
bus_addr  output  8  bus address
bus_wdata  output  16  write data; the tristate is resolved outside this block
bus_wdata_oe  output  1  write-data drive enable
bus_da  input  1  manager data acknowledge
bus_data  input  16  manager read data

Behaviour:
- Reset state: gnt=0, done=0, rdata=0, err=0, bus_as=0, bus_ds=0, bus_rw=1, bus_addr=0, bus_wdata=0, bus_wdata_oe=0, FSM=IDLE, rr pointer=0.
- All outputs are registered. Reset asserted mid-transfer drops every strobe in the same cycle and discards the transfer; no done pulse is issued.
- FSM states:
  - IDLE: if any req, select the first set req scanning upward from rr pointer, wrapping modulo NUM_REQ. Latch that requester's rw/addr/wdata, set gnt one-hot. Go to ADDR.
  - ADDR: bus_as=1, bus_rw and bus_addr driven. For a write, bus_wdata_oe=1. Go to STROBE after exactly 1 cycle.
  - STROBE: bus_ds=1, held until bus_da=1. On bus_da=1:
    - For a read, capture bus_data into rdata.
    - Go to RELEASE.
  - RELEASE: bus_as=0, bus_ds=0, bus_wdata_oe=0. Pulse done for the granted requester. Wait for bus_da=0, then clear gnt and go to IDLE. done is pulsed only on the first RELEASE cycle.
- rr pointer becomes (granted index + 1) mod NUM_REQ on entry to RELEASE.
- Minimum transfer: IDLE→ADDR→STROBE (da seen the same cycle)→RELEASE→IDLE. That is 4 cycles from the grant cycle, with done in cycle 4.
- A requester may re-raise req in the cycle after done. It is then arbitrated fairly against the others.
- Requests dropped while in ADDR/STROBE are ignored; the transfer completes.
- bus_da already high in IDLE is ignored.
- Write-data drive covers ADDR through STROBE, so the manager samples it while ds=1.
- Addresses wrap naturally at 8 bits; the arbiter does no address arithmetic.

Optional Feature:
- Q_BUS_ARB_TIMEOUT_EN defined:
  - An 8-bit-minimum counter runs in STROBE.
  - If bus_da is not seen within TIMEOUT_CYC cycles, go to RELEASE with err=1 pulsed alongside done, and rdata=16'hDEAD.
  - RELEASE then does not wait for da=0 beyond TIMEOUT_CYC cycles.
- Q_BUS_ARB_TIMEOUT_EN undefined: STROBE waits indefinitely, and err is tied 0.

Decomposition:
- Shared package q_bus_pkg: state enum (IDLE, ADDR, STROBE, RELEASE), address/data width constants (8, 16), timeout error pattern 16'hDEAD.
- Sub-module q_rr_picker: combinational round-robin first-one-from-pointer selector.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index.
  - Instantiated once.

Test Plan:
- Single read: req[0]=1, rw=1, addr=8'h3C; manager raises da 2 cycles after ds with data 16'hBEEF -> as/ds sequence correct, done[0] pulses once, rdata=16'hBEEF, err=0.
- Write: req[2]=1, rw=0, addr=8'hFF, wdata=16'h1234 -> bus_wdata_oe=1 through ADDR/STROBE, bus_addr=8'hFF, done[2] pulses after da.
- Contention: req=4'b1111 held -> grants in order 0,1,2,3,0, each transfer has no gnt overlap, and no requester is granted twice in a row while others wait.
- Back-to-back: req[1] re-raised right after done with req[3] pending -> req[3] is granted next.
- Reset in STROBE: assert rst while ds=1 -> as/ds/gnt drop immediately, no done; after release a new req completes normally.
- Timeout (macro on, TIMEOUT_CYC=8): da never asserted -> after 8 STROBE cycles done and err pulse together, rdata=16'hDEAD, next requester granted.
